// File: rtl/mvau_inp_buf_ctrl_if.sv
// Handshake and buffer-control bundle between the MVAU input stream, the
// input activation buffer and the PE/SIMD array.
interface mvau_inp_buf_ctrl_if #(
    parameter int BUF_ADDR = 4,
    parameter int NF_W     = 2
);
    logic                in_v;
    logic                in_rdy;
    logic                out_stall;
    logic                wr_en;
    logic                rd_en;
    logic [BUF_ADDR-1:0] addr;
    logic                do_mvau;
    logic                sf_clr;
    logic                sf_last;
    logic [NF_W-1:0]     nf_cnt;

    // Stream source and array side: drives valid/back-pressure, observes controls.
    modport master (
        output in_v, out_stall,
        input  in_rdy, wr_en, rd_en, addr, do_mvau, sf_clr, sf_last, nf_cnt
    );

    // Controller side.
    modport slave (
        input  in_v, out_stall,
        output in_rdy, wr_en, rd_en, addr, do_mvau, sf_clr, sf_last, nf_cnt
    );
endinterface

// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input buffer controller: writes each SF-beat activation vector once
// during neuron fold 0, then replays it from the buffer for folds 1..NF-1.
module mvau_inp_buf_ctrl #(
    parameter int SF       = 16,
    parameter int NF       = 4,
    parameter int BUF_ADDR = (SF > 1) ? $clog2(SF) : 1,
    parameter int NF_W     = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mvau_inp_buf_ctrl_if.slave   bus
);
    typedef enum logic {
        MODE_WRITE = 1'b0,
        MODE_READ  = 1'b1
    } mode_t;

    localparam logic [BUF_ADDR-1:0] SF_LAST = BUF_ADDR'(SF - 1);
    localparam logic [NF_W-1:0]     NF_LAST = NF_W'(NF - 1);

    mode_t               mode;
    logic [BUF_ADDR-1:0] sf_cnt;
    logic [NF_W-1:0]     nf_q;
    logic                fire;

    // A beat advances when downstream can take it and, in WRITE, a live beat
    // is present; READ beats come from the buffer so they need no input.
    assign fire = rst_n && !bus.out_stall && ((mode == MODE_READ) || bus.in_v);

    // in_rdy depends only on state and out_stall, never on in_v.
    assign bus.in_rdy  = rst_n && (mode == MODE_WRITE) && !bus.out_stall;
    assign bus.wr_en   = fire && (mode == MODE_WRITE);
    assign bus.rd_en   = rst_n && (mode == MODE_READ);
    assign bus.addr    = rst_n ? sf_cnt : '0;
    assign bus.nf_cnt  = rst_n ? nf_q : '0;
    assign bus.do_mvau = fire;
    assign bus.sf_clr  = fire && (sf_cnt == '0);
    assign bus.sf_last = fire && (sf_cnt == SF_LAST);

    // NOTE: all state is updated with non-blocking assignments so each
    // register sees pre-edge values of the others within the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode   <= MODE_WRITE;
            sf_cnt <= '0;
            nf_q   <= '0;
        end else if (fire) begin
            if (sf_cnt != SF_LAST) begin
                sf_cnt <= sf_cnt + 1'b1;
            end else begin
                sf_cnt <= '0;
                // Wrap back to WRITE after the last fold; with NF=1 this
                // keeps the controller in WRITE permanently.
                if (nf_q == NF_LAST) begin
                    nf_q <= '0;
                    mode <= MODE_WRITE;
                end else begin
                    nf_q <= nf_q + 1'b1;
                    mode <= MODE_READ;
                end
            end
        end
    end
endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Directed bench for mvau_inp_buf_ctrl: SF=4/NF=3, SF=1/NF=1 and SF=3/NF=1
// instances, each output cycle compared against hand-computed vectors.
module tb_mvau_inp_buf_ctrl;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mvau_inp_buf_ctrl_if #(.BUF_ADDR(2), .NF_W(2)) if_a ();
    mvau_inp_buf_ctrl_if #(.BUF_ADDR(1), .NF_W(1)) if_b ();
    mvau_inp_buf_ctrl_if #(.BUF_ADDR(2), .NF_W(1)) if_c ();

    mvau_inp_buf_ctrl #(.SF(4), .NF(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    mvau_inp_buf_ctrl #(.SF(1), .NF(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    mvau_inp_buf_ctrl #(.SF(3), .NF(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {in_rdy, wr_en, rd_en, do_mvau, sf_clr, sf_last, addr[3:0], nf_cnt[3:0]}
    function automatic int pack(logic rdy, logic wr, logic rd, logic dm, logic clr,
                                logic last, int addr, int nf);
        return {18'd0, rdy, wr, rd, dm, clr, last, addr[3:0], nf[3:0]};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %04h expected %04h (rdy,wr,rd,do,clr,last|addr|nf)",
                   tag, obs, exp);
        end
    endtask

    // Each step: drive inputs just after a rising edge, compare at the falling
    // edge, then let the next rising edge commit the state change.
    task automatic step_a(input string tag, input logic v, input logic st,
                          input logic rdy, input logic wr, input logic rd, input int addr,
                          input logic dm, input logic clr, input logic last, input int nf);
        if_a.in_v = v;
        if_a.out_stall = st;
        @(negedge clk);
        check(tag, pack(if_a.in_rdy, if_a.wr_en, if_a.rd_en, if_a.do_mvau, if_a.sf_clr,
                        if_a.sf_last, int'(if_a.addr), int'(if_a.nf_cnt)),
              pack(rdy, wr, rd, dm, clr, last, addr, nf));
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input string tag, input logic v, input logic st,
                          input logic rdy, input logic wr, input logic rd, input int addr,
                          input logic dm, input logic clr, input logic last, input int nf);
        if_b.in_v = v;
        if_b.out_stall = st;
        @(negedge clk);
        check(tag, pack(if_b.in_rdy, if_b.wr_en, if_b.rd_en, if_b.do_mvau, if_b.sf_clr,
                        if_b.sf_last, int'(if_b.addr), int'(if_b.nf_cnt)),
              pack(rdy, wr, rd, dm, clr, last, addr, nf));
        @(posedge clk);
        #1;
    endtask

    task automatic step_c(input string tag, input logic v, input logic st,
                          input logic rdy, input logic wr, input logic rd, input int addr,
                          input logic dm, input logic clr, input logic last, input int nf);
        if_c.in_v = v;
        if_c.out_stall = st;
        @(negedge clk);
        check(tag, pack(if_c.in_rdy, if_c.wr_en, if_c.rd_en, if_c.do_mvau, if_c.sf_clr,
                        if_c.sf_last, int'(if_c.addr), int'(if_c.nf_cnt)),
              pack(rdy, wr, rd, dm, clr, last, addr, nf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        if_a.in_v = 1'b0; if_a.out_stall = 1'b0;
        if_b.in_v = 1'b0; if_b.out_stall = 1'b0;
        if_c.in_v = 1'b0; if_c.out_stall = 1'b0;

        // Reset: outputs forced low even with a valid beat offered.
        step_a("rst0", 1, 0, 0,0,0,0, 0,0,0,0);
        step_a("rst1", 1, 0, 0,0,0,0, 0,0,0,0);
        rst_n = 1'b1;

        // Streaming, no stall: 4 writes, 8 replays, then a new vector.
        //                     v st rdy wr rd a  do clr last nf
        step_a("s_w0",  1, 0, 1,1,0,0, 1,1,0,0);
        step_a("s_w1",  1, 0, 1,1,0,1, 1,0,0,0);
        step_a("s_w2",  1, 0, 1,1,0,2, 1,0,0,0);
        step_a("s_w3",  1, 0, 1,1,0,3, 1,0,1,0);
        step_a("s_r10", 1, 0, 0,0,1,0, 1,1,0,1);
        step_a("s_r11", 1, 0, 0,0,1,1, 1,0,0,1);
        step_a("s_r12", 1, 0, 0,0,1,2, 1,0,0,1);
        step_a("s_r13", 1, 0, 0,0,1,3, 1,0,1,1);
        step_a("s_r20", 1, 0, 0,0,1,0, 1,1,0,2);
        step_a("s_r21", 1, 0, 0,0,1,1, 1,0,0,2);
        step_a("s_r22", 1, 0, 0,0,1,2, 1,0,0,2);
        step_a("s_r23", 1, 0, 0,0,1,3, 1,0,1,2);
        step_a("s_w0b", 1, 0, 1,1,0,0, 1,1,0,0);

        // Input gap after beat 0: address holds at 1.
        step_a("g_hold0", 0, 0, 1,0,0,1, 0,0,0,0);
        step_a("g_hold1", 0, 0, 1,0,0,1, 0,0,0,0);
        step_a("g_w1",    1, 0, 1,1,0,1, 1,0,0,0);
        step_a("g_w2",    1, 0, 1,1,0,2, 1,0,0,0);
        step_a("g_w3",    1, 0, 1,1,0,3, 1,0,1,0);
        step_a("g_r10",   1, 0, 0,0,1,0, 1,1,0,1);
        step_a("g_r11",   1, 0, 0,0,1,1, 1,0,0,1);

        // Stall in READ at nf=1, addr=2: frozen, no framing strobes.
        step_a("st_0",    1, 1, 0,0,1,2, 0,0,0,1);
        step_a("st_1",    1, 1, 0,0,1,2, 0,0,0,1);
        step_a("st_2",    1, 1, 0,0,1,2, 0,0,0,1);
        step_a("st_r12",  1, 0, 0,0,1,2, 1,0,0,1);
        step_a("st_r13",  1, 0, 0,0,1,3, 1,0,1,1);
        step_a("st_r20",  1, 0, 0,0,1,0, 1,1,0,2);
        step_a("st_r21",  1, 0, 0,0,1,1, 1,0,0,2);
        step_a("st_r22",  1, 0, 0,0,1,2, 1,0,0,2);
        step_a("st_r23",  1, 0, 0,0,1,3, 1,0,1,2);

        // Stall in WRITE with a valid beat: not ready, nothing written.
        step_a("wst",     1, 1, 0,0,0,0, 0,0,0,0);
        step_a("wst_w0",  1, 0, 1,1,0,0, 1,1,0,0);
        step_a("p_w1",    1, 0, 1,1,0,1, 1,0,0,0);
        step_a("p_w2",    1, 0, 1,1,0,2, 1,0,0,0);
        step_a("p_w3",    1, 0, 1,1,0,3, 1,0,1,0);
        step_a("p_r10",   1, 0, 0,0,1,0, 1,1,0,1);
        step_a("p_r11",   1, 0, 0,0,1,1, 1,0,0,1);
        step_a("p_r12",   1, 0, 0,0,1,2, 1,0,0,1);
        step_a("p_r13",   1, 0, 0,0,1,3, 1,0,1,1);
        step_a("p_r20",   1, 0, 0,0,1,0, 1,1,0,2);

        // Mid-operation reset at READ nf=2, addr=1.
        rst_n = 1'b0;
        step_a("mrst",    1, 0, 0,0,0,0, 0,0,0,0);
        rst_n = 1'b1;
        step_a("mrst_w0", 1, 0, 1,1,0,0, 1,1,0,0);
        if_a.in_v = 1'b0;

        // SF=1, NF=1: every beat both opens and closes a row, never READ.
        step_b("b_w0",   1, 0, 1,1,0,0, 1,1,1,0);
        step_b("b_w1",   1, 0, 1,1,0,0, 1,1,1,0);
        step_b("b_w2",   1, 0, 1,1,0,0, 1,1,1,0);
        step_b("b_idle", 0, 0, 1,0,0,0, 0,0,0,0);
        step_b("b_st",   1, 1, 0,0,0,0, 0,0,0,0);
        step_b("b_w3",   1, 0, 1,1,0,0, 1,1,1,0);
        if_b.in_v = 1'b0;

        // SF=3, NF=1: address wraps 0,1,2,0 while staying in WRITE.
        step_c("c_w0",   1, 0, 1,1,0,0, 1,1,0,0);
        step_c("c_w1",   1, 0, 1,1,0,1, 1,0,0,0);
        step_c("c_w2",   1, 0, 1,1,0,2, 1,0,1,0);
        step_c("c_w0b",  1, 0, 1,1,0,0, 1,1,0,0);
        step_c("c_w1b",  1, 0, 1,1,0,1, 1,0,0,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
